// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/issue scheduler with RAW scoreboard and jump hold
//
// Purpose: owns the fetch-valid flag and a scoreboard of in-flight instructions
// (OF, EX, MEM, WB). Drives the PC and issue-register enables, stalls decode on
// RAW register hazards and holds fetch while a jump is in flight.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   dec_src0/_used            decoded source reg 0 and its read flag
//   dec_src1/_used            decoded source reg 1 and its read flag
//   dec_dst, dec_writes       decoded destination reg and its write flag
//   dec_is_jump               decoded instruction is a jump
//   pc_en, pc_sel_jump        PC enable; PC loads resolved jump target
//   issue_reg_en              issue register captures memory read data
//   issue_accept              decoded instruction enters OF this cycle
//   stall                     valid instruction held by a hazard
//   stage_valid[DEPTH]        valid bit per scoreboard stage
//   stall_count[CNT_W]        saturating count of stall cycles
module pipeline_hazard_controller #(
  parameter int DEPTH      = 4,
  parameter int JUMP_STAGE = 1,
  parameter int CNT_W      = 16,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       dec_src0,
  input  logic             dec_src0_used,
  input  logic [4:0]       dec_src1,
  input  logic             dec_src1_used,
  input  logic [4:0]       dec_dst,
  input  logic             dec_writes,
  input  logic             dec_is_jump,
  output logic             pc_en,
  output logic             pc_sel_jump,
  output logic             issue_reg_en,
  output logic             issue_accept,
  output logic             stall,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CNT_W-1:0] stall_count
);

  logic             fetch_valid;
  logic             jump_pending;
  logic [DEPTH-1:0] sb_valid;
  logic [DEPTH-1:0] sb_writes;
  logic [DEPTH-1:0] sb_is_jump;
  logic [4:0]       sb_dst [DEPTH];

  logic hazard;
  logic jump_load;
  logic fetch;

  // A producer blocks readers through its WB stage: the register file is only
  // written at the end of WB and there is no forwarding path.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sb_valid[k] && sb_writes[k]) begin
        if (dec_src0_used && (sb_dst[k] == dec_src0) && !(ZERO_REG && (dec_src0 == 5'd0)))
          hazard = 1'b1;
        if (dec_src1_used && (sb_dst[k] == dec_src1) && !(ZERO_REG && (dec_src1 == 5'd0)))
          hazard = 1'b1;
      end
    end
    hazard = hazard & fetch_valid;
  end

  assign issue_accept = fetch_valid & ~hazard & ~jump_pending;
  assign stall        = hazard;
  assign jump_load    = sb_valid[JUMP_STAGE] & sb_is_jump[JUMP_STAGE];
  // Nothing past an accepted jump is fetched, so the pipe never needs a flush.
  assign fetch        = ~jump_pending & ~(issue_accept & dec_is_jump) &
                        (~fetch_valid | issue_accept);
  assign pc_en        = fetch | jump_load;
  assign pc_sel_jump  = jump_load;
  assign issue_reg_en = fetch;
  assign stage_valid  = sb_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_valid  <= 1'b0;
      jump_pending <= 1'b0;
      sb_valid     <= '0;
      sb_writes    <= '0;
      sb_is_jump   <= '0;
      for (int k = 0; k < DEPTH; k++) sb_dst[k] <= 5'd0;
      stall_count  <= '0;
    end else begin
      // Scoreboard advances every cycle; there is no downstream backpressure.
      for (int k = DEPTH - 1; k > 0; k--) begin
        sb_valid[k]   <= sb_valid[k-1];
        sb_writes[k]  <= sb_writes[k-1];
        sb_is_jump[k] <= sb_is_jump[k-1];
        sb_dst[k]     <= sb_dst[k-1];
      end
      sb_valid[0]   <= issue_accept;
      sb_writes[0]  <= issue_accept & dec_writes;
      sb_is_jump[0] <= issue_accept & dec_is_jump;
      sb_dst[0]     <= dec_dst;

      if (fetch)
        fetch_valid <= 1'b1;
      else if (issue_accept)
        fetch_valid <= 1'b0;

      // Set and clear are exclusive: jump_load only occurs while pending,
      // and a jump cannot be accepted while pending.
      if (issue_accept && dec_is_jump)
        jump_pending <= 1'b1;
      else if (jump_load)
        jump_pending <= 1'b0;

      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - self-checking bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  localparam int DEPTH = 4;
  localparam int JS    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] dec_src0, dec_src1, dec_dst;
  logic       dec_src0_used, dec_src1_used, dec_writes, dec_is_jump;

  logic             pc_en, pc_sel_jump, issue_reg_en, issue_accept, stall;
  logic [DEPTH-1:0] stage_valid;
  logic [15:0]      stall_count;

  logic             pc_en_s, pc_sel_jump_s, issue_reg_en_s, issue_accept_s, stall_s;
  logic [DEPTH-1:0] stage_valid_s;
  logic [3:0]       stall_count_s;

  pipeline_hazard_controller dut (
    .clk(clk), .rst(rst),
    .dec_src0(dec_src0), .dec_src0_used(dec_src0_used),
    .dec_src1(dec_src1), .dec_src1_used(dec_src1_used),
    .dec_dst(dec_dst), .dec_writes(dec_writes), .dec_is_jump(dec_is_jump),
    .pc_en(pc_en), .pc_sel_jump(pc_sel_jump), .issue_reg_en(issue_reg_en),
    .issue_accept(issue_accept), .stall(stall),
    .stage_valid(stage_valid), .stall_count(stall_count)
  );

  pipeline_hazard_controller #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .dec_src0(dec_src0), .dec_src0_used(dec_src0_used),
    .dec_src1(dec_src1), .dec_src1_used(dec_src1_used),
    .dec_dst(dec_dst), .dec_writes(dec_writes), .dec_is_jump(dec_is_jump),
    .pc_en(pc_en_s), .pc_sel_jump(pc_sel_jump_s), .issue_reg_en(issue_reg_en_s),
    .issue_accept(issue_accept_s), .stall(stall_s),
    .stage_valid(stage_valid_s), .stall_count(stall_count_s)
  );

  // Reference: list of accepted instructions with their accept cycle. An
  // instruction sits in stage (cycle - accept - 1) while that is below DEPTH.
  typedef struct {
    int       issue;
    bit [4:0] dst;
    bit       writes;
    bit       is_jump;
  } rec_t;

  rec_t             q[$];
  int               cyc = 0;
  bit               m_fv = 1'b0;
  int               m_stalls = 0;
  bit               m_haz, m_jpend, m_jload, m_acc, m_fetch;
  logic [DEPTH-1:0] m_sv;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit reads(input bit [4:0] r);
    return (dec_src0_used && dec_src0 == r) || (dec_src1_used && dec_src1 == r);
  endfunction

  task automatic model_eval();
    int st;
    m_haz = 0; m_jpend = 0; m_jload = 0; m_sv = '0;
    foreach (q[i]) begin
      st = cyc - q[i].issue - 1;
      if (st >= 0 && st < DEPTH) begin
        m_sv[st] = 1'b1;
        if (q[i].writes && reads(q[i].dst)) m_haz = 1;
        if (q[i].is_jump && st <= JS) m_jpend = 1;
        if (q[i].is_jump && st == JS) m_jload = 1;
      end
    end
    m_haz   = m_haz & m_fv;
    m_acc   = m_fv & !m_haz & !m_jpend;
    m_fetch = !m_jpend && !(m_acc && dec_is_jump) && (!m_fv || m_acc);
  endtask

  task automatic compare_all();
    chk("pc_en", pc_en, m_fetch | m_jload);
    chk("pc_sel_jump", pc_sel_jump, m_jload);
    chk("issue_reg_en", issue_reg_en, m_fetch);
    chk("issue_accept", issue_accept, m_acc);
    chk("stall", stall, m_haz);
    chk("stage_valid", stage_valid, m_sv);
    chk("stall_count", stall_count, (m_stalls > 65535) ? 65535 : m_stalls);
    chk("stall_count_w4", stall_count_s, (m_stalls > 15) ? 15 : m_stalls);
    chk("pc_en_w4", pc_en_s, m_fetch | m_jload);
  endtask

  // Called at the negedge: apply inputs, let them settle, compare.
  task automatic drive(input bit r, input bit [4:0] s0, input bit u0, input bit [4:0] s1,
                       input bit u1, input bit [4:0] d, input bit w, input bit j);
    rst = r; dec_src0 = s0; dec_src0_used = u0; dec_src1 = s1; dec_src1_used = u1;
    dec_dst = d; dec_writes = w; dec_is_jump = j;
    #1;
    model_eval();
    if (r) compare_all();
  endtask

  task automatic adv();
    if (!rst) begin
      q.delete(); m_fv = 0; m_stalls = 0;
    end else begin
      if (m_acc) q.push_back('{cyc, dec_dst, dec_writes, dec_is_jump});
      m_fv = m_fetch ? 1'b1 : (m_acc ? 1'b0 : m_fv);
      if (m_haz) m_stalls++;
    end
    cyc++;
    while (q.size() > 0 && (cyc - q[0].issue - 1) >= DEPTH) void'(q.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic nop();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    adv();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      adv();
    end
  endtask

  task automatic chk_clean();
    chk("rst_pc_en", pc_en, 1);
    chk("rst_issue_reg_en", issue_reg_en, 1);
    chk("rst_pc_sel_jump", pc_sel_jump, 0);
    chk("rst_stage_valid", stage_valid, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_stall", stall, 0);
    chk("rst_issue_accept", issue_accept, 0);
  endtask

  initial begin
    @(negedge clk);

    // Reset state
    do_reset(3);
    drive(1, 0, 0, 0, 0, 0, 0, 0); chk_clean(); adv();

    // Independent ALU ops issue back to back
    drive(1, 2, 1, 3, 1, 1, 1, 0);
    chk("indep_acc0", issue_accept, 1); chk("indep_stall0", stall, 0); adv();
    drive(1, 5, 1, 6, 1, 4, 1, 0);
    chk("indep_acc1", issue_accept, 1); chk("indep_stall1", stall, 0); adv();
    for (int i = 0; i < 6; i++) nop();

    // Back-to-back RAW: DEPTH stall cycles
    do_reset(1); nop();
    drive(1, 2, 1, 3, 1, 1, 1, 0); chk("raw_prod_acc", issue_accept, 1); adv();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 1, 1, 7, 1, 0);
      chk("raw_stall", stall, 1); chk("raw_hold", issue_accept, 0); adv();
    end
    drive(1, 1, 1, 1, 1, 7, 1, 0);
    chk("raw_acc", issue_accept, 1); chk("raw_stall_end", stall, 0);
    chk("raw_count", stall_count, 4); adv();

    // Jump timing
    do_reset(1); nop();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    chk("jmp_acc", issue_accept, 1); chk("jmp_t_pc_en", pc_en, 0); adv();
    nop_chk: begin
      drive(1, 0, 0, 0, 0, 0, 0, 0); chk("jmp_t1_pc_en", pc_en, 0); adv();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      chk("jmp_t2_pc_en", pc_en, 1); chk("jmp_t2_sel", pc_sel_jump, 1); adv();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      chk("jmp_t3_fetch", issue_reg_en, 1); chk("jmp_t3_sel", pc_sel_jump, 0); adv();
      drive(1, 0, 0, 0, 0, 0, 0, 0); chk("jmp_t4_acc", issue_accept, 1); adv();
    end

    // Stall counter saturation on the 4-bit instance: chain r1<-r1+r1
    do_reset(1); nop();
    for (int i = 2; i <= 27; i++) begin
      drive(1, 1, 1, 1, 1, 1, 1, 0);
      if (i == 27) begin
        chk("sat_count16", stall_count, 20);
        chk("sat_count4", stall_count_s, 15);
      end
      adv();
    end

    // Reset while a stall is in flight
    do_reset(1); nop();
    drive(1, 2, 1, 3, 1, 1, 1, 0); adv();
    drive(1, 1, 1, 0, 0, 9, 1, 0); chk("midrst_stall", stall, 1); adv();
    do_reset(1);
    drive(1, 0, 0, 0, 0, 0, 0, 0); chk_clean(); adv();

    // Reset while a jump is pending
    drive(1, 0, 0, 0, 0, 0, 0, 1); chk("midrst_jmp_acc", issue_accept, 1); adv();
    do_reset(1);
    drive(1, 0, 0, 0, 0, 0, 0, 0); chk_clean(); adv();

    // Randomized traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 199) != 0),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 99) < 8));
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
